// File: rtl/link_rx_scheduler_pkg.sv
// Shared definitions for the link receive scheduler: register map,
// FSM state encoding and link count.
package link_rx_scheduler_pkg;

  localparam int NLINKS = 4;

  localparam logic [3:0] REG_HEAD0  = 4'd0;
  localparam logic [3:0] REG_TAIL0  = 4'd4;
  localparam logic [3:0] REG_ENABLE = 4'd8;
  localparam logic [3:0] REG_STATUS = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    WRITE = 2'd2
  } rxState_e;

  // One-hot link select from a link index.
  function automatic logic [NLINKS-1:0] oneHot(input logic [1:0] idx);
    logic [NLINKS-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/link_rx_scheduler_rr_arb4.sv
// Four-way round-robin arbiter. Purely combinational: the search starts
// at the requester after last_i and wraps, so last_i has lowest priority.
module rr_arb4
  import link_rx_scheduler_pkg::*;
(
  input  logic [NLINKS-1:0] request_i,
  input  logic [1:0]        last_i,
  output logic [1:0]        grant_o,
  output logic              valid_o
);

  logic [1:0] cand;

  // Scan from the farthest candidate back to last+1 so the nearest requester wins.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int i = NLINKS; i >= 1; i--) begin
      cand = last_i + 2'(i);
      if (request_i[cand]) begin
        grant_o = cand;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/link_rx_scheduler.sv
// Round-robin receive scheduler: pops words from four link endpoints and
// writes them into four per-link ring buffers in node RAM.
module link_rx_scheduler
  import link_rx_scheduler_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [19:0] BASE       = 20'h01000
) (
  input  logic                   clk,
  input  logic                   resetb,
  input  logic [NLINKS-1:0]      link_dor,
  input  logic [NLINKS-1:0][31:0] link_dout,
  output logic [NLINKS-1:0]      link_cs,
  output logic                   link_rd,
  output logic                   ram_req,
  input  logic                   ram_gnt,
  output logic [19:0]            ram_addr,
  output logic [31:0]            ram_din,
  input  logic                   reg_cs,
  input  logic                   reg_we,
  input  logic [3:0]             reg_addr,
  input  logic [31:0]            reg_wdata,
  output logic [31:0]            reg_rdata
);

  rxState_e              state_q;
  logic [1:0]            grant_q;
  logic [1:0]            last_q;
  logic [DEPTH_LOG2-1:0] head_q [NLINKS];
  logic [DEPTH_LOG2-1:0] tail_q [NLINKS];
  logic [NLINKS-1:0]     enable_q;
  logic [NLINKS-1:0]     link_cs_q;
  logic                  link_rd_q;
  logic                  ram_req_q;
  logic [19:0]           ram_addr_q;
  logic [31:0]           ram_din_q;

  logic [19:0]           ramAddr_d;
  logic [NLINKS-1:0]     full;
  logic [NLINKS-1:0]     eligible;
  logic [1:0]            arbGrant;
  logic                  arbValid;
  logic                  busy;
  logic                  regWrite;
  logic                  unusedWdata;

  assign busy        = (state_q != IDLE);
  assign regWrite    = reg_cs & reg_we;
  assign unusedWdata = ^reg_wdata;

  // A ring is full when advancing head would collide with the CPU's tail.
  always_comb begin
    full = '0;
    for (int n = 0; n < NLINKS; n++) begin
      full[n] = ((head_q[n] + DEPTH_LOG2'(1)) == tail_q[n]);
    end
  end

  assign eligible = link_dor & enable_q & ~full;

  // Ring slot address for the granted link's current head.
  always_comb begin
    ramAddr_d = BASE + (20'(grant_q) << DEPTH_LOG2) + 20'(head_q[grant_q]);
  end

  rr_arb4 uArb (
    .request_i (eligible),
    .last_i    (last_q),
    .grant_o   (arbGrant),
    .valid_o   (arbValid)
  );

  // Transfer FSM: pick a link, pop its word, then hold the RAM write until granted.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= 2'd3;
      link_cs_q  <= '0;
      link_rd_q  <= 1'b0;
      ram_req_q  <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      for (int n = 0; n < NLINKS; n++) begin
        head_q[n] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (arbValid) begin
            grant_q   <= arbGrant;
            link_cs_q <= oneHot(arbGrant);
            link_rd_q <= 1'b1;
            state_q   <= POP;
          end
        end
        POP: begin
          link_cs_q  <= '0;
          link_rd_q  <= 1'b0;
          ram_din_q  <= link_dout[grant_q];
          ram_addr_q <= ramAddr_d;
          ram_req_q  <= 1'b1;
          last_q     <= grant_q;
          state_q    <= WRITE;
        end
        WRITE: begin
          if (ram_gnt) begin
            head_q[grant_q] <= head_q[grant_q] + DEPTH_LOG2'(1);
            ram_req_q       <= 1'b0;
            state_q         <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // CPU-writable registers: tail indices and the per-link enable mask.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      enable_q <= '0;
      for (int n = 0; n < NLINKS; n++) begin
        tail_q[n] <= '0;
      end
    end else if (regWrite) begin
      if (reg_addr[3:2] == REG_TAIL0[3:2]) begin
        tail_q[reg_addr[1:0]] <= reg_wdata[DEPTH_LOG2-1:0];
      end else if (reg_addr == REG_ENABLE) begin
        enable_q <= reg_wdata[NLINKS-1:0];
      end
    end
  end

  // Register read mux; unmapped indices read as zero.
  always_comb begin
    reg_rdata = '0;
    if (reg_addr[3:2] == REG_HEAD0[3:2]) begin
      reg_rdata = 32'(head_q[reg_addr[1:0]]);
    end else if (reg_addr[3:2] == REG_TAIL0[3:2]) begin
      reg_rdata = 32'(tail_q[reg_addr[1:0]]);
    end else if (reg_addr == REG_ENABLE) begin
      reg_rdata = {28'd0, enable_q};
    end else if (reg_addr == REG_STATUS) begin
      reg_rdata = {27'd0, busy, full};
    end
  end

  assign link_cs  = link_cs_q;
  assign link_rd  = link_rd_q;
  assign ram_req  = ram_req_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;

endmodule

// File: tb/tb_link_rx_scheduler.sv
// Directed self-checking bench for link_rx_scheduler. Instance A uses the
// default 256-word rings; instance B uses 4-word rings to reach full quickly.
module tb_link_rx_scheduler;

  logic            clk = 1'b0;
  logic            resetb;
  logic [3:0]      link_dor;
  logic [3:0][31:0] link_dout;
  logic            ram_gnt;
  logic            reg_cs;
  logic            reg_we;
  logic [3:0]      reg_addr;
  logic [31:0]     reg_wdata;

  logic [3:0]  aLinkCs, bLinkCs;
  logic        aLinkRd, bLinkRd;
  logic        aRamReq, bRamReq;
  logic [19:0] aRamAddr, bRamAddr;
  logic [31:0] aRamDin, bRamDin;
  logic [31:0] aRegRdata, bRegRdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  link_rx_scheduler #(.DEPTH_LOG2(8), .BASE(20'h01000)) dutA (
    .clk(clk), .resetb(resetb),
    .link_dor(link_dor), .link_dout(link_dout),
    .link_cs(aLinkCs), .link_rd(aLinkRd),
    .ram_req(aRamReq), .ram_gnt(ram_gnt),
    .ram_addr(aRamAddr), .ram_din(aRamDin),
    .reg_cs(reg_cs), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(aRegRdata)
  );

  link_rx_scheduler #(.DEPTH_LOG2(2), .BASE(20'h01000)) dutB (
    .clk(clk), .resetb(resetb),
    .link_dor(link_dor), .link_dout(link_dout),
    .link_cs(bLinkCs), .link_rd(bLinkRd),
    .ram_req(bRamReq), .ram_gnt(ram_gnt),
    .ram_addr(bRamAddr), .ram_din(bRamDin),
    .reg_cs(reg_cs), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(bRegRdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] dor, input logic gnt);
    link_dor = dor;
    ram_gnt  = gnt;
  endtask

  task automatic regWrite(input logic [3:0] addr, input logic [31:0] data);
    reg_cs    = 1'b1;
    reg_we    = 1'b1;
    reg_addr  = addr;
    reg_wdata = data;
    tick();
    reg_cs    = 1'b0;
    reg_we    = 1'b0;
  endtask

  task automatic doReset();
    resetb    = 1'b0;
    link_dor  = '0;
    link_dout = '0;
    ram_gnt   = 1'b0;
    reg_cs    = 1'b0;
    reg_we    = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    tick();
    tick();
    resetb = 1'b1;
  endtask

  // Directed test sequence, one scenario after another.
  initial begin
    logic [1:0]  rrGrant [5];
    logic [19:0] rrAddr  [5];
    logic [1:0]  mkGrant [4];
    logic [19:0] mkAddr  [4];

    rrGrant = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rrAddr  = '{20'h01000, 20'h01100, 20'h01200, 20'h01300, 20'h01001};
    mkGrant = '{2'd1, 2'd3, 2'd1, 2'd3};
    mkAddr  = '{20'h01100, 20'h01300, 20'h01101, 20'h01301};

    // Reset state
    doReset();
    checkOutput("rst_cs", aLinkCs, 4'h0);
    checkOutput("rst_rd", aLinkRd, 1'b0);
    checkOutput("rst_req", aRamReq, 1'b0);
    checkOutput("rst_addr", aRamAddr, 20'h0);
    checkOutput("rst_din", aRamDin, 32'h0);
    reg_addr = 4'd8; #1;
    checkOutput("rst_enable", aRegRdata, 32'h0);
    reg_addr = 4'd9; #1;
    checkOutput("rst_status", aRegRdata, 32'h0);

    // Single link, 3-cycle latency
    regWrite(4'd8, 32'h1);
    link_dout[0] = 32'hCAFE0001;
    applyStimulus(4'b0001, 1'b1);
    tick();
    checkOutput("single_pop_cs", aLinkCs, 4'b0001);
    checkOutput("single_pop_rd", aLinkRd, 1'b1);
    checkOutput("single_pop_req", aRamReq, 1'b0);
    tick();
    checkOutput("single_wr_cs", aLinkCs, 4'b0000);
    checkOutput("single_wr_rd", aLinkRd, 1'b0);
    checkOutput("single_wr_req", aRamReq, 1'b1);
    checkOutput("single_wr_addr", aRamAddr, 20'h01000);
    checkOutput("single_wr_din", aRamDin, 32'hCAFE0001);
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkOutput("single_done_req", aRamReq, 1'b0);
    reg_addr = 4'd0; #1;
    checkOutput("single_head0", aRegRdata, 32'h1);
    reg_addr = 4'd9; #1;
    checkOutput("single_status", aRegRdata, 32'h0);

    // Round-robin over all four links
    doReset();
    regWrite(4'd8, 32'hF);
    for (int n = 0; n < 4; n++) link_dout[n] = 32'h11110000 + 32'(n);
    applyStimulus(4'b1111, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput($sformatf("rr_cs_%0d", k), aLinkCs, 4'b0001 << rrGrant[k]);
      tick();
      checkOutput($sformatf("rr_addr_%0d", k), aRamAddr, rrAddr[k]);
      checkOutput($sformatf("rr_din_%0d", k), aRamDin, 32'h11110000 + 32'(rrGrant[k]));
      tick();
    end

    // Full ring on the 4-word instance
    doReset();
    regWrite(4'd8, 32'h1);
    link_dout[0] = 32'hB0B00000;
    applyStimulus(4'b0001, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("full_cs_%0d", k), bLinkCs, 4'b0001);
      tick();
      checkOutput($sformatf("full_addr_%0d", k), bRamAddr, 20'h01000 + 20'(k));
      tick();
    end
    reg_addr = 4'd9; #1;
    checkOutput("full_status", bRegRdata, 32'h1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("full_skip_cs_%0d", k), bLinkCs, 4'b0000);
      checkOutput($sformatf("full_skip_req_%0d", k), bRamReq, 1'b0);
    end
    regWrite(4'd4, 32'h1);
    tick();
    checkOutput("full_resume_cs", bLinkCs, 4'b0001);
    tick();
    checkOutput("full_resume_req", bRamReq, 1'b1);
    checkOutput("full_resume_addr", bRamAddr, 20'h01003);
    tick();
    reg_addr = 4'd0; #1;
    checkOutput("full_head_wrap", bRegRdata, 32'h0);
    reg_addr = 4'd9; #1;
    checkOutput("full_again_status", bRegRdata, 32'h1);
    tick();
    checkOutput("full_again_cs", bLinkCs, 4'b0000);

    // RAM stall holds the write stable
    doReset();
    regWrite(4'd8, 32'h2);
    link_dout[1] = 32'h51510001;
    applyStimulus(4'b0010, 1'b0);
    tick();
    checkOutput("stall_pop_cs", aLinkCs, 4'b0010);
    tick();
    checkOutput("stall_req0", aRamReq, 1'b1);
    applyStimulus(4'b0000, 1'b0);
    reg_addr = 4'd9;
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput($sformatf("stall_req_%0d", k), aRamReq, 1'b1);
      checkOutput($sformatf("stall_addr_%0d", k), aRamAddr, 20'h01100);
      checkOutput($sformatf("stall_din_%0d", k), aRamDin, 32'h51510001);
      checkOutput($sformatf("stall_cs_%0d", k), aLinkCs, 4'b0000);
      checkOutput($sformatf("stall_busy_%0d", k), aRegRdata, 32'h10);
    end
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkOutput("stall_done_req", aRamReq, 1'b0);
    reg_addr = 4'd1; #1;
    checkOutput("stall_head1", aRegRdata, 32'h1);

    // Enable mask restricts grants to links 1 and 3
    doReset();
    regWrite(4'd8, 32'hA);
    for (int n = 0; n < 4; n++) link_dout[n] = 32'h22220000 + 32'(n);
    applyStimulus(4'b1111, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput($sformatf("mask_cs_%0d", k), aLinkCs, 4'b0001 << mkGrant[k]);
      tick();
      checkOutput($sformatf("mask_addr_%0d", k), aRamAddr, mkAddr[k]);
      checkOutput($sformatf("mask_din_%0d", k), aRamDin, 32'h22220000 + 32'(mkGrant[k]));
      tick();
      checkOutput($sformatf("mask_idle_cs_%0d", k), aLinkCs & 4'b0101, 4'b0000);
    end

    // Asynchronous reset in the middle of a write
    doReset();
    regWrite(4'd4, 32'h5);
    regWrite(4'd8, 32'hF);
    for (int n = 0; n < 4; n++) link_dout[n] = 32'hD00D0000 + 32'(n);
    applyStimulus(4'b1111, 1'b0);
    tick();
    tick();
    checkOutput("midrst_req_before", aRamReq, 1'b1);
    #1;
    resetb = 1'b0;
    #1;
    checkOutput("midrst_req", aRamReq, 1'b0);
    checkOutput("midrst_addr", aRamAddr, 20'h0);
    checkOutput("midrst_din", aRamDin, 32'h0);
    checkOutput("midrst_cs", aLinkCs, 4'h0);
    checkOutput("midrst_rd", aLinkRd, 1'b0);
    reg_addr = 4'd8; #1;
    checkOutput("midrst_enable", aRegRdata, 32'h0);
    reg_addr = 4'd4; #1;
    checkOutput("midrst_tail0", aRegRdata, 32'h0);
    reg_addr = 4'd9; #1;
    checkOutput("midrst_status", aRegRdata, 32'h0);
    tick();
    resetb = 1'b1;
    regWrite(4'd8, 32'hF);
    applyStimulus(4'b1111, 1'b1);
    tick();
    checkOutput("postrst_cs", aLinkCs, 4'b0001);
    tick();
    checkOutput("postrst_addr", aRamAddr, 20'h01000);
    checkOutput("postrst_din", aRamDin, 32'hD00D0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/link_rx_scheduler.md
# link_rx_scheduler

Round-robin receive scheduler for the four serial link endpoints of a node. It drains received words from the link host interfaces and writes them into four per-link circular buffers in node RAM, so the CPU never polls link data registers. It sits between the four link host ports and a spare RAM write port, and is programmed by the CPU through a small I/O register window.

## Interface
- DEPTH_LOG2, 8: log2 of words per link ring buffer.
- BASE, 20'h01000: word address of link 0 ring; link n ring starts at BASE + n*2^DEPTH_LOG2.
- clk  in  1  clock.
- resetb  in  1  reset, asynchronous, active-low.
- link_dor  in  4  per-link receive word available.
- link_dout  in  4x32  per-link receive data; head word presented combinationally while link_dor is high.
- link_cs  out  4  one-hot link select; pops the word when high together with link_rd.
- link_rd  out  1  read strobe to links.
- ram_req  out  1  write request to RAM port.
- ram_gnt  in  1  RAM port granted this cycle; the write occurs on that edge.
- ram_addr  out  20  RAM word address.
- ram_din  out  32  RAM write data.
- reg_cs  in  1  register window select.
- reg_we  in  1  register write strobe (qualified by reg_cs).
- reg_addr  in  4  register index.
- reg_wdata  in  32  register write data.
- reg_rdata  out  32  register read data, combinational from reg_addr.

## Operation
- Registers: 0–3 head[n] (RO, DEPTH_LOG2 bits, zero-extended); 4–7 tail[n] (RW, the CPU consumer index, write masked to DEPTH_LOG2 bits); 8 enable[3:0] (RW); 9 status = {busy[4], full[3:0]} (RO); other indices read 0 and ignore writes.
- full[n] = ((head[n]+1) mod 2^DEPTH_LOG2 == tail[n]). One slot is always unused, so capacity is 2^DEPTH_LOG2−1 words.
- Eligible[n] = link_dor[n] & enable[n] & !full[n].
- FSM states IDLE, POP, WRITE:
  - IDLE: if any link is eligible, grant the first eligible link searching from last+1 (mod 4), then go to POP. Otherwise stay in IDLE.
  - POP (1 cycle): link_cs[g]=1 and link_rd=1. Capture link_dout[g] into the data register and compute ram_addr = BASE + g*2^DEPTH_LOG2 + head[g]. Set last=g and go to WRITE.
  - WRITE: hold ram_req=1 with ram_addr and ram_din stable until ram_gnt=1. On that edge, increment head[g] (wraps at 2^DEPTH_LOG2) and go to IDLE.
- busy = (state != IDLE).
- Clearing enable[g] during POP or WRITE does not abort the transfer; the captured word is still written.
- A CPU tail write in the same cycle as a head increment: both take effect. Full is re-evaluated the next cycle.
- A CPU tail write that makes a ring appear full or empty inconsistently is not checked; the CPU owns tail correctness.
- If the grant-winner's link_dor drops between IDLE and POP, this is a protocol violation; the links hold dor until popped.

## Timing
- Reset values: link_cs=0, link_rd=0, ram_req=0, ram_addr=0, ram_din=0, all head=0, all tail=0, enable=0, last=3 (so link 0 wins first), state=IDLE.
- Reset mid-operation forces IDLE immediately. A word already popped but not yet written is lost.
- Minimum latency from link_dor rising to the RAM write edge is 3 cycles (IDLE decide, POP, WRITE with ram_gnt=1). Peak throughput is one word per 3 cycles.
- ram_req is registered. It asserts on the cycle after POP and deasserts on the cycle after the granting edge.
- Register writes take effect on the next clk edge. head/status reads reflect registered values.

## Structure
- Shared package: register index constants (REG_HEAD0=0, REG_TAIL0=4, REG_ENABLE=8, REG_STATUS=9), FSM state encoding, link count constant NLINKS=4.
- One sub-module: rr_arb4, a 4-way round-robin arbiter (request[3:0], last[1:0] → grant index + valid). It is purely combinational and reused for the TX scheduler later.

## Test plan
- Single link: enable=4'h1; link 0 presents 32'hCAFE0001 with ram_gnt held at 1 → write to 20'h01000 on the 3rd edge; head0=1; link_cs=4'b0001 for exactly one cycle.
- Round-robin: all four links dor=1 continuously, enable=4'hF → grants in order 0,1,2,3,0; addresses 01000, 01100, 01200, 01300, 01001.
- Full ring: DEPTH_LOG2=2, tail0=0, link 0 streams → 3 words written, then full[0]=1 and link 0 is skipped; writing tail0=1 resumes with exactly one more write to 01003, after which head0 wraps to 0.
- RAM stall: ram_gnt=0 for 5 cycles in WRITE → ram_req, ram_addr and ram_din stay stable, no new pop occurs, and busy=1 throughout.
- Enable mask: enable=4'b1010 with all dor=1 → only links 1 and 3 are ever selected.
- Reset mid-WRITE: assert resetb=0 during WRITE → all outputs and registers return to their reset values asynchronously, and the next write after release goes to 01000 from link 0.
